// File: rtl/bt656cap_colorconv.sv
// BT.601 YCbCr 4:2:2 (two pixels per word) to packed RGB565 pair, three register stages.
// Latency 3 cycles when not stalled; one global enable stalls every stage while the output is held unaccepted.
module bt656cap_colorconv (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_stb,
    output logic        i_ack,
    input  logic        i_field,
    input  logic [31:0] i_ycc,
    output logic        o_stb,
    input  logic        o_ack,
    output logic        o_field,
    output logic [31:0] o_rgb565
);

    logic               r_v1, r_v2, r_v3;
    logic               r_f1, r_f2;
    logic signed [9:0]  r_y0o, r_y1o, r_cbo, r_cro;
    logic signed [19:0] r_p_y0, r_p_y1, r_p_rcr, r_p_gcb, r_p_gcr, r_p_bcb;
    logic [31:0]        r_rgb;
    logic               r_field;

    logic               w_en;
    logic signed [19:0] w_y0x, w_y1x, w_cbx, w_crx;
    logic signed [19:0] w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;
    logic [7:0]         w_r0c, w_g0c, w_b0c, w_r1c, w_g1c, w_b1c;

    // Sums are always below 2^19, so for non-negative values any bit in [18:16] means > 255.
    function automatic logic [7:0] clamp8(input logic signed [19:0] s);
        logic [7:0] v;
        if (s[19])
            v = 8'd0;
        else if (|s[18:16])
            v = 8'hFF;
        else
            v = s[15:8];
        return v;
    endfunction

    assign w_en  = ~r_v3 | o_ack;
    assign i_ack = w_en;

    assign w_y0x = {{10{r_y0o[9]}}, r_y0o};
    assign w_y1x = {{10{r_y1o[9]}}, r_y1o};
    assign w_cbx = {{10{r_cbo[9]}}, r_cbo};
    assign w_crx = {{10{r_cro[9]}}, r_cro};

    assign w_r0 = r_p_y0 + r_p_rcr + 20'sd128;
    assign w_g0 = r_p_y0 - r_p_gcb - r_p_gcr + 20'sd128;
    assign w_b0 = r_p_y0 + r_p_bcb + 20'sd128;
    assign w_r1 = r_p_y1 + r_p_rcr + 20'sd128;
    assign w_g1 = r_p_y1 - r_p_gcb - r_p_gcr + 20'sd128;
    assign w_b1 = r_p_y1 + r_p_bcb + 20'sd128;

    assign w_r0c = clamp8(w_r0);
    assign w_g0c = clamp8(w_g0);
    assign w_b0c = clamp8(w_b0);
    assign w_r1c = clamp8(w_r1);
    assign w_g1c = clamp8(w_g1);
    assign w_b1c = clamp8(w_b1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_f1    <= 1'b0;
            r_f2    <= 1'b0;
            r_y0o   <= '0;
            r_y1o   <= '0;
            r_cbo   <= '0;
            r_cro   <= '0;
            r_p_y0  <= '0;
            r_p_y1  <= '0;
            r_p_rcr <= '0;
            r_p_gcb <= '0;
            r_p_gcr <= '0;
            r_p_bcb <= '0;
            r_rgb   <= '0;
            r_field <= 1'b0;
        end else if (w_en) begin
            // Bubbles travel with the data so every stage keeps its slot.
            r_v1    <= i_stb;
            r_f1    <= i_field;
            r_cbo   <= $signed({2'b00, i_ycc[31:24]}) - 10'sd128;
            r_y0o   <= $signed({2'b00, i_ycc[23:16]}) - 10'sd16;
            r_cro   <= $signed({2'b00, i_ycc[15:8]})  - 10'sd128;
            r_y1o   <= $signed({2'b00, i_ycc[7:0]})   - 10'sd16;

            r_v2    <= r_v1;
            r_f2    <= r_f1;
            r_p_y0  <= w_y0x * 20'sd298;
            r_p_y1  <= w_y1x * 20'sd298;
            r_p_rcr <= w_crx * 20'sd409;
            r_p_gcb <= w_cbx * 20'sd100;
            r_p_gcr <= w_crx * 20'sd208;
            r_p_bcb <= w_cbx * 20'sd516;

            r_v3    <= r_v2;
            r_field <= r_f2;
            r_rgb   <= {w_r0c[7:3], w_g0c[7:2], w_b0c[7:3],
                        w_r1c[7:3], w_g1c[7:2], w_b1c[7:3]};
        end
    end

    assign o_stb    = r_v3;
    assign o_field  = r_field;
    assign o_rgb565 = r_rgb;

endmodule

// File: tb/tb_bt656cap_colorconv.sv
// Scoreboard bench for the YCbCr-to-RGB565 pipeline: directed colours, latency, bubbles, backpressure, reset flush.
module tb_bt656cap_colorconv;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        i_stb   = 1'b0;
    logic        i_ack;
    logic        i_field = 1'b0;
    logic [31:0] i_ycc   = '0;
    logic        o_stb;
    logic        o_ack   = 1'b1;
    logic        o_field;
    logic [31:0] o_rgb565;

    int          n_chk = 0;
    int          n_err = 0;
    logic [32:0] sb_q[$];
    logic [32:0] sb_exp;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rgb   = '0;
    logic        prev_field = 1'b0;

    bt656cap_colorconv dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i_stb    (i_stb),
        .i_ack    (i_ack),
        .i_field  (i_field),
        .i_ycc    (i_ycc),
        .o_stb    (o_stb),
        .o_ack    (o_ack),
        .o_field  (o_field),
        .o_rgb565 (o_rgb565)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp_ref(input int s);
        if (s < 0) return 8'd0;
        if ((s >>> 8) > 255) return 8'd255;
        return 8'((s >>> 8) & 255);
    endfunction

    function automatic logic [15:0] pix_ref(input int y, input int cb, input int cr);
        int yy, r, g, b;
        logic [7:0] rc, gc, bc;
        yy = 298 * (y - 16);
        r  = yy + 409 * (cr - 128) + 128;
        g  = yy - 100 * (cb - 128) - 208 * (cr - 128) + 128;
        b  = yy + 516 * (cb - 128) + 128;
        rc = clamp_ref(r);
        gc = clamp_ref(g);
        bc = clamp_ref(b);
        return {rc[7:3], gc[7:2], bc[7:3]};
    endfunction

    function automatic logic [31:0] word_ref(input logic [31:0] ycc);
        return {pix_ref(int'(ycc[23:16]), int'(ycc[31:24]), int'(ycc[15:8])),
                pix_ref(int'(ycc[7:0]),   int'(ycc[31:24]), int'(ycc[15:8]))};
    endfunction

    // Push on acceptance, pop on output transfer; both sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {o_stb, o_field, o_rgb565}, {1'b1, prev_field, prev_rgb});
            if (o_stb && !o_ack)
                chk("stall_iack", i_ack, 0);
            prev_stall = o_stb && !o_ack;
            prev_rgb   = o_rgb565;
            prev_field = o_field;
            if (o_stb && o_ack) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_word", {o_field, o_rgb565}, sb_exp);
                end
            end
            if (i_stb && i_ack)
                sb_q.push_back({i_field, word_ref(i_ycc)});
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was taken, i_stb still high.
    task automatic send_word(input logic [31:0] ycc, input logic fld);
        i_stb   = 1'b1;
        i_ycc   = ycc;
        i_field = fld;
        for (int t = 0; t < 200; t++) begin
            @(negedge sys_clk);
            if (i_ack) begin
                @(posedge sys_clk);
                #1;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb_q.size() != 0; t++) begin
            @(posedge sys_clk);
            #1;
        end
        chk("drain", sb_q.size(), 0);
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    // Drives i_stb from pat with o_ack high and checks o_stb is the same pattern three cycles later.
    task automatic run_pattern(input logic [15:0] pat, input int n, input int nrun);
        logic e;
        for (int k = 0; k < nrun; k++) begin
            i_stb   = (k < n) ? pat[k] : 1'b0;
            i_ycc   = $urandom;
            i_field = 1'($urandom);
            @(negedge sys_clk);
            e = (k >= 3 && (k - 3) < n) ? pat[k-3] : 1'b0;
            chk($sformatf("pat_stb_c%0d", k), o_stb, e);
            @(posedge sys_clk);
            #1;
        end
        i_stb = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_o_stb", o_stb, 0);
        chk("rst_o_rgb", o_rgb565, 0);
        chk("rst_o_field", o_field, 0);
        chk("rst_i_ack", i_ack, 1);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("post_rst_i_ack", i_ack, 1);
        @(posedge sys_clk);
        #1;

        // Black, white, red, saturated and zero inputs.
        send_word(32'h80108010, 1'b0);
        send_word(32'h80EB80EB, 1'b1);
        send_word(32'h5A51F010, 1'b0);
        send_word(32'hFFFFFFFF, 1'b1);
        send_word(32'h00000000, 1'b0);
        i_stb = 1'b0;
        drain();

        run_pattern(16'h00FF, 8, 12);
        drain();

        run_pattern(16'h0059, 7, 11);
        drain();

        fork
            begin
                for (int w = 0; w < 16; w++)
                    send_word($urandom, 1'($urandom));
                i_stb = 1'b0;
            end
            begin
                repeat (4)  begin @(posedge sys_clk); #1; o_ack = 1'b1; end
                repeat (10) begin @(posedge sys_clk); #1; o_ack = 1'b0; end
                repeat (40) begin @(posedge sys_clk); #1; o_ack = 1'($urandom_range(0, 1)); end
                o_ack = 1'b1;
            end
        join
        drain();

        // Fill the pipe under stall, then reset with three words in flight.
        o_ack = 1'b0;
        for (int w = 0; w < 3; w++)
            send_word($urandom, 1'($urandom));
        i_stb = 1'b0;
        @(negedge sys_clk);
        chk("pre_rst_stb", o_stb, 1);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("flush_o_stb", o_stb, 0);
        chk("flush_o_rgb", o_rgb565, 0);
        @(posedge sys_clk);
        #1;
        o_ack   = 1'b1;
        i_stb   = 1'b1;
        i_ycc   = 32'h3C7AA066;
        i_field = 1'b1;
        @(negedge sys_clk);
        chk("after_rst_iack", i_ack, 1);
        @(posedge sys_clk);
        #1;
        i_stb = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge sys_clk);
            chk($sformatf("after_rst_stb_c%0d", k), o_stb, (k == 3) ? 1 : 0);
            @(posedge sys_clk);
            #1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
